// File: rtl/mem_sched.sv
// Memory-port scheduler: arbitrates I/D loads and a posted writeback FIFO
// onto one memory command slot and routes tagged answers to their owners.
module mem_sched #(
    parameter int DEPTH    = 15,
    parameter int WB_DEPTH = 4,
    parameter int IDX_W    = 30,
    parameter int BLK_W    = 64,
    localparam int TAG_W   = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ic_req,
    input  logic [IDX_W-1:0] ic_idx,
    output logic             ic_ack,
    output logic [TAG_W-1:0] ic_ack_tag,
    output logic             ic_ans,
    output logic [TAG_W-1:0] ic_ans_tag,
    output logic [BLK_W-1:0] ic_ans_blk,
    input  logic             dc_req,
    input  logic [IDX_W-1:0] dc_idx,
    output logic             dc_ack,
    output logic [TAG_W-1:0] dc_ack_tag,
    output logic             dc_ans,
    output logic [TAG_W-1:0] dc_ans_tag,
    output logic [BLK_W-1:0] dc_ans_blk,
    input  logic             ev_valid,
    input  logic [IDX_W-1:0] ev_idx,
    input  logic [BLK_W-1:0] ev_blk,
    output logic             ev_ready,
    output logic [1:0]       mem_cmd,
    output logic [IDX_W-1:0] mem_idx,
    output logic [BLK_W-1:0] mem_blk,
    input  logic [TAG_W-1:0] mem_ack,
    input  logic [TAG_W-1:0] mem_ans_tag,
    input  logic [BLK_W-1:0] mem_ans_blk,
    output logic             idle
);

    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NT    = 1 << TAG_W;

    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;

    localparam logic [1:0] OWN_IC = 2'd0;
    localparam logic [1:0] OWN_DC = 2'd1;
    localparam logic [1:0] OWN_WB = 2'd2;

    logic [IDX_W-1:0] wb_idx_q [WB_DEPTH];
    logic [IDX_W-1:0] wb_idx_d [WB_DEPTH];
    logic [BLK_W-1:0] wb_blk_q [WB_DEPTH];
    logic [BLK_W-1:0] wb_blk_d [WB_DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [NT-1:0] vld_q, vld_d;
    logic [1:0]    who_q [NT];
    logic [1:0]    who_d [NT];
    logic          rr_q, rr_d;

    logic             ic_ans_q, ic_ans_d;
    logic [TAG_W-1:0] ic_ans_tag_q, ic_ans_tag_d;
    logic [BLK_W-1:0] ic_ans_blk_q, ic_ans_blk_d;
    logic             dc_ans_q, dc_ans_d;
    logic [TAG_W-1:0] dc_ans_tag_q, dc_ans_tag_d;
    logic [BLK_W-1:0] dc_ans_blk_q, dc_ans_blk_d;

    logic             ic_haz, dc_haz;
    logic [PTR_W-1:0] off;
    logic             full, empty;
    logic             grant_ic, grant_dc, is_store;
    logic             acc, push, pop;

    assign full     = (count_q == CNT_W'(WB_DEPTH));
    assign empty    = (count_q == '0);
    assign ev_ready = (count_q < CNT_W'(WB_DEPTH));
    assign idle     = empty && (vld_q == '0);

    // Only occupied slots (offset from head below count) can hazard a load.
    always_comb begin
        ic_haz = 1'b0;
        dc_haz = 1'b0;
        off    = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            off = PTR_W'(i) - head_q;
            if ({1'b0, off} < count_q) begin
                if (ic_req && wb_idx_q[i] == ic_idx) ic_haz = 1'b1;
                if (dc_req && wb_idx_q[i] == dc_idx) dc_haz = 1'b1;
            end
        end
    end

    always_comb begin
        grant_ic = 1'b0;
        grant_dc = 1'b0;
        is_store = 1'b0;
        if (full || ic_haz || dc_haz) begin
            is_store = 1'b1;
        end else if (ic_req && dc_req) begin
            grant_ic = rr_q;
            grant_dc = !rr_q;
        end else if (dc_req) begin
            grant_dc = 1'b1;
        end else if (ic_req) begin
            grant_ic = 1'b1;
        end else if (!empty) begin
            is_store = 1'b1;
        end

        mem_cmd = CMD_NONE;
        mem_idx = '0;
        mem_blk = '0;
        if (is_store) begin
            mem_cmd = CMD_STORE;
            mem_idx = wb_idx_q[head_q];
            mem_blk = wb_blk_q[head_q];
        end else if (grant_ic) begin
            mem_cmd = CMD_LOAD;
            mem_idx = ic_idx;
        end else if (grant_dc) begin
            mem_cmd = CMD_LOAD;
            mem_idx = dc_idx;
        end

        acc        = (mem_cmd != CMD_NONE) && (mem_ack != '0);
        ic_ack     = grant_ic && acc;
        dc_ack     = grant_dc && acc;
        ic_ack_tag = ic_ack ? mem_ack : '0;
        dc_ack_tag = dc_ack ? mem_ack : '0;
        push       = ev_valid && ev_ready;
        pop        = is_store && acc;
    end

    always_comb begin
        wb_idx_d = wb_idx_q;
        wb_blk_d = wb_blk_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        vld_d    = vld_q;
        who_d    = who_q;
        rr_d     = rr_q;

        ic_ans_d     = 1'b0;
        ic_ans_tag_d = '0;
        ic_ans_blk_d = '0;
        dc_ans_d     = 1'b0;
        dc_ans_tag_d = '0;
        dc_ans_blk_d = '0;

        if (push) begin
            wb_idx_d[tail_q] = ev_idx;
            wb_blk_d[tail_q] = ev_blk;
            tail_d = tail_q + PTR_W'(1);
        end
        if (pop) head_d = head_q + PTR_W'(1);

        if (ic_ack) rr_d = 1'b0;
        if (dc_ack) rr_d = 1'b1;

        if (mem_ans_tag != '0 && vld_q[mem_ans_tag]) begin
            vld_d[mem_ans_tag] = 1'b0;
            case (who_q[mem_ans_tag])
                OWN_IC: begin
                    ic_ans_d     = 1'b1;
                    ic_ans_tag_d = mem_ans_tag;
                    ic_ans_blk_d = mem_ans_blk;
                end
                OWN_DC: begin
                    dc_ans_d     = 1'b1;
                    dc_ans_tag_d = mem_ans_tag;
                    dc_ans_blk_d = mem_ans_blk;
                end
                default: ;
            endcase
        end

        // Allocation is applied last so a same-cycle reuse of a tag wins.
        if (acc) begin
            vld_d[mem_ack] = 1'b1;
            who_d[mem_ack] = grant_ic ? OWN_IC : (grant_dc ? OWN_DC : OWN_WB);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb_idx_q     <= '{default: '0};
            wb_blk_q     <= '{default: '0};
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            vld_q        <= '0;
            who_q        <= '{default: '0};
            rr_q         <= 1'b0;
            ic_ans_q     <= 1'b0;
            ic_ans_tag_q <= '0;
            ic_ans_blk_q <= '0;
            dc_ans_q     <= 1'b0;
            dc_ans_tag_q <= '0;
            dc_ans_blk_q <= '0;
        end else begin
            wb_idx_q     <= wb_idx_d;
            wb_blk_q     <= wb_blk_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            vld_q        <= vld_d;
            who_q        <= who_d;
            rr_q         <= rr_d;
            ic_ans_q     <= ic_ans_d;
            ic_ans_tag_q <= ic_ans_tag_d;
            ic_ans_blk_q <= ic_ans_blk_d;
            dc_ans_q     <= dc_ans_d;
            dc_ans_tag_q <= dc_ans_tag_d;
            dc_ans_blk_q <= dc_ans_blk_d;
        end
    end

    assign ic_ans     = ic_ans_q;
    assign ic_ans_tag = ic_ans_tag_q;
    assign ic_ans_blk = ic_ans_blk_q;
    assign dc_ans     = dc_ans_q;
    assign dc_ans_tag = dc_ans_tag_q;
    assign dc_ans_blk = dc_ans_blk_q;

endmodule

// File: tb/tb_mem_sched.sv
// Directed bench for mem_sched: single load, fairness, full FIFO,
// hazard, same-cycle tag reuse and asynchronous reset.
module tb_mem_sched;

    logic        clock;
    logic        reset;
    logic        ic_req, dc_req;
    logic [29:0] ic_idx, dc_idx;
    logic        ic_ack, dc_ack;
    logic [3:0]  ic_ack_tag, dc_ack_tag;
    logic        ic_ans, dc_ans;
    logic [3:0]  ic_ans_tag, dc_ans_tag;
    logic [63:0] ic_ans_blk, dc_ans_blk;
    logic        ev_valid;
    logic [29:0] ev_idx;
    logic [63:0] ev_blk;
    logic        ev_ready;
    logic [1:0]  mem_cmd;
    logic [29:0] mem_idx;
    logic [63:0] mem_blk;
    logic [3:0]  mem_ack;
    logic [3:0]  mem_ans_tag;
    logic [63:0] mem_ans_blk;
    logic        idle;

    int n_chk;
    int n_fail;

    mem_sched dut (
        .clock       (clock),
        .reset       (reset),
        .ic_req      (ic_req),
        .ic_idx      (ic_idx),
        .ic_ack      (ic_ack),
        .ic_ack_tag  (ic_ack_tag),
        .ic_ans      (ic_ans),
        .ic_ans_tag  (ic_ans_tag),
        .ic_ans_blk  (ic_ans_blk),
        .dc_req      (dc_req),
        .dc_idx      (dc_idx),
        .dc_ack      (dc_ack),
        .dc_ack_tag  (dc_ack_tag),
        .dc_ans      (dc_ans),
        .dc_ans_tag  (dc_ans_tag),
        .dc_ans_blk  (dc_ans_blk),
        .ev_valid    (ev_valid),
        .ev_idx      (ev_idx),
        .ev_blk      (ev_blk),
        .ev_ready    (ev_ready),
        .mem_cmd     (mem_cmd),
        .mem_idx     (mem_idx),
        .mem_blk     (mem_blk),
        .mem_ack     (mem_ack),
        .mem_ans_tag (mem_ans_tag),
        .mem_ans_blk (mem_ans_blk),
        .idle        (idle)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        tick();
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        reset = 1'b1;
        ic_req = 0; dc_req = 0; ic_idx = '0; dc_idx = '0;
        ev_valid = 0; ev_idx = '0; ev_blk = '0;
        mem_ack = '0; mem_ans_tag = '0; mem_ans_blk = '0;
        #12 reset = 1'b0;
        #1;
        chk("rst_ev_ready", 64'(ev_ready), 64'd1);
        chk("rst_idle", 64'(idle), 64'd1);
        chk("rst_cmd", 64'(mem_cmd), 64'd0);
        chk("rst_dc_ans", 64'(dc_ans), 64'd0);
        tick();

        // single load
        dc_req = 1; dc_idx = 30'h100; mem_ack = 4'd3;
        #1;
        chk("ld_cmd", 64'(mem_cmd), 64'd1);
        chk("ld_idx", 64'(mem_idx), 64'h100);
        chk("ld_dc_ack", 64'(dc_ack), 64'd1);
        chk("ld_dc_tag", 64'(dc_ack_tag), 64'd3);
        chk("ld_ic_ack", 64'(ic_ack), 64'd0);
        tick();
        dc_req = 0; mem_ack = '0;
        #1;
        chk("ld_busy", 64'(idle), 64'd0);
        mem_ans_tag = 4'd3; mem_ans_blk = 64'hDEAD;
        tick();
        mem_ans_tag = '0; mem_ans_blk = '0;
        #1;
        chk("ld_ans", 64'(dc_ans), 64'd1);
        chk("ld_ans_tag", 64'(dc_ans_tag), 64'd3);
        chk("ld_ans_blk", dc_ans_blk, 64'hDEAD);
        chk("ld_ic_ans", 64'(ic_ans), 64'd0);
        chk("ld_idle", 64'(idle), 64'd1);
        tick();
        chk("ld_ans_low", 64'(dc_ans), 64'd0);
        chk("ld_blk_low", dc_ans_blk, 64'd0);

        // fairness
        do_reset();
        ic_req = 1; ic_idx = 30'h10; dc_req = 1; dc_idx = 30'h20;
        for (int k = 1; k <= 4; k++) begin
            if (k == 3) begin
                mem_ack = '0;
                #1;
                chk("rr_stall_dc", 64'(dc_ack), 64'd0);
                chk("rr_stall_ic", 64'(ic_ack), 64'd0);
                chk("rr_stall_idx", 64'(mem_idx), 64'h20);
                tick();
            end
            mem_ack = 4'(k);
            #1;
            chk("rr_dc_ack", 64'(dc_ack), 64'(k % 2));
            chk("rr_ic_ack", 64'(ic_ack), 64'(1 - k % 2));
            chk("rr_tag", 64'(dc_ack_tag | ic_ack_tag), 64'(k));
            tick();
        end
        ic_req = 0; dc_req = 0; mem_ack = '0;

        // FIFO full
        do_reset();
        ev_valid = 1;
        for (int k = 0; k < 4; k++) begin
            ev_idx = 30'h1000 + 30'(k);
            ev_blk = 64'hB000 + 64'(k);
            #1;
            chk("ff_ready", 64'(ev_ready), 64'd1);
            tick();
        end
        ev_valid = 0;
        dc_req = 1; dc_idx = 30'h300;
        #1;
        chk("ff_full", 64'(ev_ready), 64'd0);
        chk("ff_cmd", 64'(mem_cmd), 64'd2);
        chk("ff_idx", 64'(mem_idx), 64'h1000);
        chk("ff_blk", mem_blk, 64'hB000);
        mem_ack = 4'd5;
        #1;
        chk("ff_dc_ack", 64'(dc_ack), 64'd0);
        tick();
        mem_ack = '0;
        #1;
        chk("ff_ready_back", 64'(ev_ready), 64'd1);
        chk("ff_load", 64'(mem_cmd), 64'd1);
        dc_req = 0;
        #1;
        chk("ff_bg_idx", 64'(mem_idx), 64'h1001);
        mem_ans_tag = 4'd5; mem_ans_blk = 64'h5555;
        tick();
        mem_ans_tag = '0;
        #1;
        chk("ff_wb_dc_ans", 64'(dc_ans), 64'd0);
        chk("ff_wb_ic_ans", 64'(ic_ans), 64'd0);

        // hazard
        do_reset();
        ev_valid = 1; ev_idx = 30'h40; ev_blk = 64'h4444;
        #1;
        chk("hz_nobypass", 64'(mem_cmd), 64'd0);
        tick();
        ev_valid = 0;
        ic_req = 1; ic_idx = 30'h40;
        #1;
        chk("hz_cmd", 64'(mem_cmd), 64'd2);
        chk("hz_idx", 64'(mem_idx), 64'h40);
        mem_ack = 4'd7;
        #1;
        chk("hz_ic_ack", 64'(ic_ack), 64'd0);
        chk("hz_blk", mem_blk, 64'h4444);
        tick();
        mem_ack = '0;
        #1;
        chk("hz_load", 64'(mem_cmd), 64'd1);
        chk("hz_load_idx", 64'(mem_idx), 64'h40);
        mem_ack = 4'd8;
        #1;
        chk("hz_ack", 64'(ic_ack), 64'd1);
        chk("hz_ack_tag", 64'(ic_ack_tag), 64'd8);
        tick();
        ic_req = 0; mem_ack = '0;

        // same-cycle tag reuse
        do_reset();
        dc_req = 1; dc_idx = 30'h50; mem_ack = 4'd2;
        #1;
        chk("tr_dc_ack", 64'(dc_ack), 64'd1);
        tick();
        dc_req = 0; ic_req = 1; ic_idx = 30'h60;
        mem_ans_tag = 4'd2; mem_ans_blk = 64'hAAAA;
        #1;
        chk("tr_ic_ack", 64'(ic_ack), 64'd1);
        chk("tr_ic_tag", 64'(ic_ack_tag), 64'd2);
        tick();
        ic_req = 0; mem_ack = '0;
        mem_ans_tag = 4'd2; mem_ans_blk = 64'hBBBB;
        #1;
        chk("tr_dc_ans", 64'(dc_ans), 64'd1);
        chk("tr_dc_blk", dc_ans_blk, 64'hAAAA);
        chk("tr_ic_early", 64'(ic_ans), 64'd0);
        tick();
        mem_ans_tag = '0;
        #1;
        chk("tr_ic_ans", 64'(ic_ans), 64'd1);
        chk("tr_ic_blk", ic_ans_blk, 64'hBBBB);
        chk("tr_dc_low", 64'(dc_ans), 64'd0);
        chk("tr_idle", 64'(idle), 64'd1);

        // reset mid-transaction
        do_reset();
        dc_req = 1; dc_idx = 30'h70;
        for (int k = 1; k <= 3; k++) begin
            mem_ack = 4'(k);
            tick();
        end
        dc_req = 0; mem_ack = '0;
        ev_valid = 1;
        for (int k = 0; k < 2; k++) begin
            ev_idx = 30'h2000 + 30'(k);
            ev_blk = 64'hC000 + 64'(k);
            tick();
        end
        ev_valid = 0;
        mem_ans_tag = 4'd1; mem_ans_blk = 64'h1111;
        tick();
        mem_ans_tag = '0;
        #1;
        chk("mr_pre_ans", 64'(dc_ans), 64'd1);
        chk("mr_pre_idle", 64'(idle), 64'd0);
        #2 reset = 1'b1;
        #1;
        chk("mr_ans_clr", 64'(dc_ans), 64'd0);
        chk("mr_blk_clr", dc_ans_blk, 64'd0);
        chk("mr_idle", 64'(idle), 64'd1);
        chk("mr_ready", 64'(ev_ready), 64'd1);
        chk("mr_cmd", 64'(mem_cmd), 64'd0);
        reset = 1'b0;
        mem_ans_tag = 4'd2; mem_ans_blk = 64'h2222;
        tick();
        mem_ans_tag = '0;
        #1;
        chk("mr_late_dc", 64'(dc_ans), 64'd0);
        chk("mr_late_ic", 64'(ic_ans), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
